// File: rtl/qif_pkg.sv
// Shared types and helpers for the 8-bit QIF neuron datapath.
//   q8_t    : signed 8-bit current / weight / membrane value
//   sat8_t  : result of sat8(), clipped value plus overflow flag
//   phase_e : synapse-stage phase (accumulate or decay)
//   sat8()  : 9-bit signed -> q8_t with clip to [Q8_MIN, Q8_MAX]
package qif_pkg;

  typedef logic signed [7:0] q8_t;

  localparam q8_t Q8_MAX = 8'sh7F;
  localparam q8_t Q8_MIN = 8'sh80;

  typedef struct packed {
    q8_t  val;
    logic ovf;
  } sat8_t;

  typedef enum logic {
    PH_ACCUM = 1'b0,
    PH_DECAY = 1'b1
  } phase_e;

  function automatic sat8_t sat8(input logic signed [8:0] x);
    sat8_t r;
    if (x > 9'sd127) begin
      r.val = Q8_MAX;
      r.ovf = 1'b1;
    end else if (x < -9'sd128) begin
      r.val = Q8_MIN;
      r.ovf = 1'b1;
    end else begin
      r.val = x[7:0];
      r.ovf = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/qif_weight_ram.sv
// Synaptic weight table: N_SYN x 8-bit signed register file.
//   clk, rst_n : clock, async active-high clear (all weights -> 0)
//   we/waddr/wdata : synchronous write port
//   raddr/rdata    : asynchronous read port; a same-cycle write is not
//                    yet visible, so a colliding read sees the old weight
module qif_weight_ram
  import qif_pkg::*;
#(
  parameter int N_SYN = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  q8_t           wdata,
  input  logic [AW-1:0] raddr,
  output q8_t           rdata
);

  logic [N_SYN-1:0][7:0] mem;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) mem <= '0;
    else if (we) mem[waddr] <= wdata;
  end

  assign rdata = $signed(mem[raddr]);

endmodule

// File: rtl/qif_synapse_current.sv
// Synaptic current stage feeding the QIF neuron.
//   clk, rst_n      : clock, async active-high reset
//   ev_valid/ev_ready/ev_syn_id : presynaptic spike events (valid/ready)
//   cfg_we/cfg_addr/cfg_wdata   : weight-table programming
//   sat_clr         : clears sticky sat_flag
//   I_syn           : saturating signed 8-bit synaptic current
//   neuron_tick     : 1-cycle pulse, aligned with the freshly decayed I_syn
//   sat_flag        : sticky clip indicator (accumulate or decay)
// A free-running tick counter splits time into ACCUM cycles and one DECAY
// cycle per TICK_DIV clocks; events are back-pressured in the DECAY cycle so
// the two updates of I_syn never collide.
module qif_synapse_current
  import qif_pkg::*;
#(
  parameter int N_SYN       = 4,
  parameter int DECAY_SHIFT = 2,
  parameter int TICK_DIV    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ev_valid,
  output logic                     ev_ready,
  input  logic [$clog2(N_SYN)-1:0] ev_syn_id,
  input  logic                     cfg_we,
  input  logic [$clog2(N_SYN)-1:0] cfg_addr,
  input  q8_t                      cfg_wdata,
  input  logic                     sat_clr,
  output q8_t                      I_syn,
  output logic                     neuron_tick,
  output logic                     sat_flag
);

  localparam int AW = $clog2(N_SYN);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  // ---------------- phase FSM (state = tick counter) ----------------
  logic [CW-1:0] cnt_q, cnt_d;
  phase_e        phase;
  logic          accept, do_decay;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == CNT_LAST) cnt_d = '0;
  end

  always_comb begin
    phase    = (cnt_q == CNT_LAST) ? PH_DECAY : PH_ACCUM;
    do_decay = (phase == PH_DECAY);
    // ready drops during reset so nothing is handshaken while state clears
    ev_ready = ~do_decay & ~rst_n;
    accept   = ev_valid & ev_ready;
  end

  // ---------------- weight lookup ----------------
  q8_t w_rd;

  qif_weight_ram #(
    .N_SYN (N_SYN),
    .AW    (AW)
  ) u_wram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wdata (cfg_wdata),
    .raddr (ev_syn_id),
    .rdata (w_rd)
  );

  // ---------------- datapath ----------------
  logic signed [8:0] acc_sum, dcy_sum;
  q8_t               dcy_d;
  sat8_t             acc_sat, dcy_sat;
  logic              sat_set;

  always_comb begin
    acc_sum = $signed({I_syn[7], I_syn}) + $signed({w_rd[7], w_rd});
    acc_sat = sat8(acc_sum);

    // A small positive current would otherwise shift to 0 and never decay;
    // small negatives already shift to -1, so only the positive side needs it.
    dcy_d = I_syn >>> DECAY_SHIFT;
    if (I_syn > 8'sd0 && dcy_d == 8'sd0) dcy_d = 8'sd1;
    dcy_sum = $signed({I_syn[7], I_syn}) - $signed({dcy_d[7], dcy_d});
    dcy_sat = sat8(dcy_sum);

    sat_set = (accept & acc_sat.ovf) | (do_decay & dcy_sat.ovf);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      I_syn       <= '0;
      neuron_tick <= 1'b0;
      sat_flag    <= 1'b0;
    end else begin
      neuron_tick <= do_decay;
      if (accept)        I_syn <= acc_sat.val;
      else if (do_decay) I_syn <= dcy_sat.val;
      // a new clip wins over a simultaneous clear
      sat_flag <= sat_set | (sat_flag & ~sat_clr);
    end
  end

endmodule

// File: tb/tb_qif_synapse_current.sv
// Directed bench for qif_synapse_current (N_SYN=4, DECAY_SHIFT=2, TICK_DIV=4).
module tb_qif_synapse_current;
  import qif_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ev_valid = 1'b0;
  logic       ev_ready;
  logic [1:0] ev_syn_id = '0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_addr = '0;
  q8_t        cfg_wdata = '0;
  logic       sat_clr = 1'b0;
  q8_t        I_syn;
  logic       neuron_tick;
  logic       sat_flag;

  int n_chk = 0;
  int n_fail = 0;

  qif_synapse_current #(
    .N_SYN(4), .DECAY_SHIFT(2), .TICK_DIV(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_syn_id   (ev_syn_id),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .sat_clr     (sat_clr),
    .I_syn       (I_syn),
    .neuron_tick (neuron_tick),
    .sat_flag    (sat_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // advance one cycle; sample/drive 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input q8_t d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
  endtask

  task automatic ev(input logic [1:0] id);
    ev_valid = 1'b1; ev_syn_id = id;
  endtask

  // leaves the bench in cycle 0 after release (tick counter == 0)
  task automatic do_reset();
    ev_valid = 1'b0; cfg_we = 1'b0; sat_clr = 1'b0;
    rst_n = 1'b1;
    tick();
    ev_valid = 1'b1;
    #1;
    chk("rst_I", int'(I_syn), 0);
    chk("rst_sat", int'(sat_flag), 0);
    chk("rst_rdy", int'(ev_ready), 0);
    chk("rst_tick", int'(neuron_tick), 0);
    ev_valid = 1'b0;
    tick();
    rst_n = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_chk %0d", n_chk);
    $fatal(1);
  end

  initial begin
    // ---- reset release and first tick ----
    do_reset();
    #1 chk("c0_rdy", int'(ev_ready), 1);
    tick(); tick(); tick();                   // cycle 3 = DECAY
    chk("c3_rdy", int'(ev_ready), 0);
    chk("c3_tick", int'(neuron_tick), 0);
    tick();                                   // cycle 4
    chk("c4_tick", int'(neuron_tick), 1);
    tick();
    chk("c5_tick", int'(neuron_tick), 0);

    // ---- accumulate, stall across DECAY, saturate, clear ----
    do_reset();
    wr(2'd1, 8'sd40); tick();                 // c1
    wr(2'd2, -8'sd100); tick();               // c2
    wr(2'd0, 8'sd5); tick();                  // c3
    cfg_we = 1'b0;
    chk("b_decay_rdy", int'(ev_ready), 0);
    tick();                                   // c4
    chk("b_zero_tick", int'(neuron_tick), 1);
    chk("b_zero_I", int'(I_syn), 0);
    ev(2'd1); tick();                         // c5
    chk("acc1", int'(I_syn), 40);
    tick();                                   // c6
    chk("acc2", int'(I_syn), 80);
    tick();                                   // c7 DECAY, event held
    chk("acc3", int'(I_syn), 120);
    chk("hold_rdy", int'(ev_ready), 0);
    tick();                                   // c8: decayed, no accept in DECAY
    chk("stall_I", int'(I_syn), 90);
    chk("stall_tick", int'(neuron_tick), 1);
    chk("stall_rdy", int'(ev_ready), 1);
    tick();                                   // c9: 90+40 clips
    ev_valid = 1'b0;
    chk("sat_pos_I", int'(I_syn), 127);
    chk("sat_pos_flag", int'(sat_flag), 1);
    sat_clr = 1'b1; tick();                   // c10
    sat_clr = 1'b0;
    chk("sat_clr", int'(sat_flag), 0);
    chk("exact_cnt", int'(I_syn), 127);
    tick(); tick();                           // c12
    chk("decay127", int'(I_syn), 96);
    ev(2'd1); tick();                         // c13
    chk("burst_I", int'(I_syn), 127);
    #2 rst_n = 1'b1;
    #1;
    chk("midrst_I", int'(I_syn), 0);
    chk("midrst_rdy", int'(ev_ready), 0);
    chk("midrst_sat", int'(sat_flag), 0);

    // ---- negative clip, clr priority, same-cycle write collision ----
    do_reset();
    wr(2'd2, -8'sd100); tick();               // c1
    wr(2'd0, 8'sd5); ev(2'd2); tick();        // c2
    cfg_we = 1'b0;
    chk("neg1", int'(I_syn), -100);
    sat_clr = 1'b1; tick();                   // c3
    sat_clr = 1'b0; ev_valid = 1'b0;
    chk("neg2", int'(I_syn), -128);
    chk("neg_flag_prio", int'(sat_flag), 1);
    tick();                                   // c4
    chk("neg_decay", int'(I_syn), -96);
    wr(2'd0, 8'sd10); ev(2'd0); tick();       // c5
    cfg_we = 1'b0;
    chk("coll_old_w", int'(I_syn), -91);
    tick();                                   // c6
    ev_valid = 1'b0;
    chk("coll_new_w", int'(I_syn), -81);
    tick(); tick();                           // c8
    chk("neg_decay81", int'(I_syn), -60);

    // ---- decay sequences ----
    do_reset();
    wr(2'd1, 8'sd100); tick();                // c1
    cfg_we = 1'b0; ev(2'd1); tick();          // c2
    ev_valid = 1'b0;
    chk("d_load", int'(I_syn), 100);
    tick(); tick();                           // c4
    chk("d75", int'(I_syn), 75);
    repeat (4) tick();
    chk("d57", int'(I_syn), 57);
    repeat (4) tick();
    chk("d43", int'(I_syn), 43);

    do_reset();
    wr(2'd1, 8'sd1); tick();                  // c1
    wr(2'd2, -8'sd3); ev(2'd1); tick();       // c2
    cfg_we = 1'b0; ev_valid = 1'b0;
    chk("d_one", int'(I_syn), 1);
    tick(); tick();                           // c4
    chk("d_one_zero", int'(I_syn), 0);
    ev(2'd2); tick();                         // c5
    ev_valid = 1'b0;
    chk("d_m3", int'(I_syn), -3);
    repeat (3) tick();                        // c8
    chk("d_m2", int'(I_syn), -2);
    repeat (4) tick();
    chk("d_m1", int'(I_syn), -1);
    repeat (4) tick();
    chk("d_m0", int'(I_syn), 0);
    repeat (4) tick();
    chk("d_stay0", int'(I_syn), 0);
    chk("d_noclip", int'(sat_flag), 0);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/qif_synapse_current.md
Name: qif_synapse_current

Overview:
- Upstream stage of the 8-bit QIF neuron; produces the signed synaptic current I_syn that the neuron integrates.
- Accepts presynaptic spike events over a valid/ready handshake and looks up each event's signed weight in a small programmable table.
- Adds the weight into a saturating 8-bit current accumulator.
- Applies exponential decay of the current once per neuron tick, and emits the tick pulse that paces the neuron stage.

Parameters:
- N_SYN, 4, number of synapse inputs / weight-table entries (power of 2).
- DECAY_SHIFT, 2, decay per tick is I >>> DECAY_SHIFT (time constant ≈ 2^DECAY_SHIFT ticks).
- TICK_DIV, 4, clk cycles per neuron tick (≥2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-high.
- ev_valid  in  1  spike event present.
- ev_ready  out  1  stage can accept an event this cycle.
- ev_syn_id  in  $clog2(N_SYN)  synapse index of the event.
- cfg_we  in  1  weight-table write strobe.
- cfg_addr  in  $clog2(N_SYN)  weight-table index.
- cfg_wdata  in  8  signed weight (two's complement).
- sat_clr  in  1  clears sat_flag.
- I_syn  out  8  signed synaptic current to the neuron.
- neuron_tick  out  1  one-cycle pulse on the cycle the decay is applied.
- sat_flag  out  1  sticky: an accumulate or decay result was clipped.

Behaviour:
- Reset (rst_n=1, async): I_syn=0, neuron_tick=0, sat_flag=0, tick counter=0, all weights=0. ev_ready=0 while reset is asserted.
- Tick counter: counts 0..TICK_DIV-1 and wraps. The cycle with count==TICK_DIV-1 is the DECAY cycle; all other cycles are ACCUM cycles. The first DECAY cycle after reset release is cycle TICK_DIV-1.
- ev_ready: combinational, equal to NOT(DECAY cycle) AND NOT rst_n. Decay and accumulation therefore never coincide.
- ACCUM cycle with ev_valid & ev_ready:
  - I_syn <= sat8(I_syn + w[ev_syn_id]), computed at 9-bit signed width.
  - Result is registered: visible the cycle after acceptance (latency 1).
  - One event accepted per cycle maximum.
- Saturation: results clip to the range [-128, +127]. Any clip sets sat_flag.
- ACCUM cycle without a handshake: I_syn holds.
- DECAY cycle:
  - d = I_syn >>> DECAY_SHIFT (arithmetic shift).
  - If I_syn > 0 and d == 0, force d = 1. Negative values already yield d = -1 when small.
  - I_syn <= I_syn - d, so the current reaches exactly 0 and I_syn == 0 stays 0.
  - neuron_tick = 1 registered, so it is high in the cycle after the DECAY cycle, aligned with the decayed I_syn.
- Handshake: the producer holds ev_valid/ev_syn_id stable until ev_ready. If ev_valid is asserted in a DECAY cycle, the event is accepted in the next cycle and nothing is dropped.
- Weight table:
  - Synchronous write on cfg_we.
  - An event in the same cycle as a write to the same index uses the OLD weight.
  - Writes are allowed in any cycle, including the DECAY cycle.
- sat_flag: set has priority over sat_clr in the same cycle.
- Reset mid-operation: all state clears immediately. No pending event survives; the producer must re-present it.
- States: ACCUM (default) and DECAY, selected purely by the tick counter. No other states.

Decomposition:
- Shared package qif_pkg holds:
  - typedef q8_t (signed 8-bit).
  - Constants Q8_MAX = 127 and Q8_MIN = -128.
  - Function sat8 (9-bit signed to q8_t with overflow flag), reused by the neuron stage.
- One natural sub-module: qif_weight_ram, an N_SYN x 8 register file with async read, sync write, and async reset to 0.

Test Plan:
- Reset: hold rst_n=1 then release → I_syn=0, sat_flag=0, ev_ready=0 during reset; first neuron_tick appears 4 cycles after release (DECAY at cycle 3, registered pulse at cycle 4).
- Accumulate: write w[1]=+40, send three id=1 events in ACCUM cycles → I_syn=40, 80, 120, each one cycle after its handshake.
- Saturation: from I_syn=120, event with w[1]=+40 → I_syn=127, sat_flag=1. Pulse sat_clr → sat_flag=0.
- Negative clip: w[2]=-100, two events from 0 → -100 then -128, sat_flag=1.
- Decay: I_syn=100, no events → successive ticks give 75, 57, 43. I_syn=1 → 0. I_syn=-3 → -2, -1, 0, then stays 0.
- Collision:
  - ev_valid held through a DECAY cycle → ev_ready=0 there, event accepted the following cycle, count of accepted events is exact.
  - cfg write of w[0]=+10 (old value 5) in the same cycle as an id=0 event → I_syn increases by 5.
  - Assert rst_n mid-burst → I_syn=0 immediately.
